dmem_access_ctrl: RTL and testbench

- Sequences data-memory accesses issued by the memory stage toward a multi-cycle, req/ack data memory.
- Converts byte, halfword and word loads/stores into word-aligned bus transactions with big-endian byte enables.
- Formats load data: lane extraction plus sign or zero extension.
- Drives a pipeline stall while an access is outstanding. Sits between the memory stage and the data memory, and feeds the memory stage's dMemValue input.

---
 rtl/dmem_access_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: data-memory access sequencer between the memory stage and a
// multi-cycle req/ack data memory. Word-aligns byte/halfword/word accesses with
// big-endian byte enables, formats load data, and stalls the pipeline while a
// bus transaction is outstanding.
// Optional feature: define DMEM_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES
// cycles without mem_ack (bus_err_out pulse, rdata_out cleared).
module dmem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite_in,
    input  logic        MemToReg_in,
    input  logic [0:31] addr_in,
    input  logic [0:31] wdata_in,
    input  logic [0:1]  DSize_in,
    input  logic        loadSign_in,
    output logic        stall_out,
    output logic [0:31] rdata_out,
    output logic        misalign_out,
    output logic        bus_err_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [0:31] mem_addr,
    output logic [0:3]  mem_be,
    output logic [0:31] mem_wdata,
    input  logic        mem_ack,
    input  logic [0:31] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateType;

    stateType    state, nextState;
    logic        isAccess, isWord, isHalf, misaligned, accept;
    logic [0:3]  beNext;
    logic [0:31] wdataNext;
    logic [0:1]  sizeReg, offReg;
    logic        signReg, isLoadReg;
    logic [0:7]  loadByte;
    logic [0:15] loadHalf;
    logic [0:31] fmtData;
    logic        timeoutHit;

    // The counter width must be able to hold the abort threshold.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TO_W)) begin : gBadTimeoutCfg
        $error("dmem_access_ctrl: TO_W too narrow for TIMEOUT_CYCLES");
    end

    // Request decode; a simultaneous load and store request is treated as a store.
    assign isAccess   = MemWrite_in | MemToReg_in;
    assign isWord     = DSize_in[0];
    assign isHalf     = (DSize_in == 2'b01);
    assign misaligned = (isHalf & addr_in[31]) | (isWord & (addr_in[30:31] != 2'b00));
    assign accept     = (state == IDLE) & isAccess & ~misaligned;

    // Byte enables and lane-replicated store data for the incoming request.
    always_comb begin
        if (isWord) begin
            beNext    = 4'b1111;
            wdataNext = wdata_in;
        end else if (isHalf) begin
            beNext    = addr_in[30] ? 4'b0011 : 4'b1100;
            wdataNext = {2{wdata_in[16:31]}};
        end else begin
            beNext    = 4'b1000 >> addr_in[30:31];
            wdataNext = {4{wdata_in[24:31]}};
        end
    end

    // Lane extraction and sign/zero extension using the attributes latched at issue.
    always_comb begin
        loadByte = mem_rdata[{offReg, 3'b000} +: 8];
        loadHalf = offReg[0] ? mem_rdata[16:31] : mem_rdata[0:15];
        if (sizeReg[0]) begin
            fmtData = mem_rdata;
        end else if (sizeReg == 2'b01) begin
            fmtData = {{16{signReg & loadHalf[0]}}, loadHalf};
        end else begin
            fmtData = {{24{signReg & loadByte[0]}}, loadByte};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state decode plus stall, request and misalignment outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        nextState    = state;
        stall_out    = 1'b0;
        misalign_out = 1'b0;
        mem_req      = 1'b0;
        case (state)
            IDLE: begin
                if (isAccess) begin
                    if (misaligned) begin
                        misalign_out = 1'b1;
                    end else begin
                        stall_out = 1'b1;
                        nextState = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_out = 1'b1;
                mem_req   = 1'b1;
                if (mem_ack || timeoutHit) nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Bus-side registers, loaded once when an aligned request is accepted.
    always_ff @(posedge clk) begin
        // NOTE: these data registers are reset because every output must read 0
        // after reset, not merely the control state.
        if (reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
            sizeReg   <= '0;
            offReg    <= '0;
            signReg   <= 1'b0;
            isLoadReg <= 1'b0;
        end else if (accept) begin
            mem_addr  <= {addr_in[0:29], 2'b00};
            mem_we    <= MemWrite_in;
            mem_be    <= beNext;
            mem_wdata <= wdataNext;
            sizeReg   <= DSize_in;
            offReg    <= addr_in[30:31];
            signReg   <= loadSign_in;
            isLoadReg <= ~MemWrite_in;
        end
    end

    // Load result register: captured on ack for loads, cleared on abort, else held.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_out <= '0;
        end else if ((state == BUSY) && mem_ack && isLoadReg) begin
            rdata_out <= fmtData;
        end else if (timeoutHit) begin
            rdata_out <= '0;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] toCnt;
    logic            busErrReg;

    // An ack in the final allowed cycle wins over the abort.
    assign timeoutHit  = (state == BUSY) && !mem_ack && (toCnt == TO_LAST);
    assign bus_err_out = busErrReg;

    // Timeout counter: cleared on entry to BUSY, counts BUSY cycles without ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            toCnt <= '0;
        end else if (accept) begin
            toCnt <= '0;
        end else if ((state == BUSY) && !mem_ack) begin
            toCnt <= toCnt + 1'b1;
        end
    end

    // Error pulse registered on the abort edge, so it is high during DONE only.
    always_ff @(posedge clk) begin
        if (reset) busErrReg <= 1'b0;
        else       busErrReg <= timeoutHit;
    end
`else
    assign timeoutHit  = 1'b0;
    assign bus_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite_in, MemToReg_in, loadSign_in;
    logic [0:31] addr_in, wdata_in;
    logic [0:1]  DSize_in;
    logic        stall_out, misalign_out, bus_err_out;
    logic [0:31] rdata_out;
    logic        mem_req, mem_we, mem_ack;
    logic [0:31] mem_addr, mem_wdata, mem_rdata;
    logic [0:3]  mem_be;

    int checks   = 0;
    int failures = 0;

    // Observations from one access sequence.
    int          obsStall;
    logic [0:31] obsAddr, obsWdata, obsRdata;
    logic [0:3]  obsBe;
    logic        obsWe, obsReq, obsDoneStall, obsDoneReq, obsErr;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
        .clk(clk), .reset(reset),
        .MemWrite_in(MemWrite_in), .MemToReg_in(MemToReg_in),
        .addr_in(addr_in), .wdata_in(wdata_in), .DSize_in(DSize_in),
        .loadSign_in(loadSign_in),
        .stall_out(stall_out), .rdata_out(rdata_out),
        .misalign_out(misalign_out), .bus_err_out(bus_err_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        MemWrite_in = 1'b0;
        MemToReg_in = 1'b0;
        addr_in     = '0;
        wdata_in    = '0;
        DSize_in    = 2'b00;
        loadSign_in = 1'b0;
    endtask

    // Issue one request in the current IDLE cycle, keep it held while BUSY,
    // ack in BUSY cycle ackAt (0 = never) and spend busyCycles cycles in BUSY.
    // Returns at the IDLE cycle following DONE.
    task automatic runAccess(input logic we, input logic ld, input logic [0:31] addr,
                             input logic [0:31] wdata, input logic [0:1] size,
                             input logic sgn, input int busyCycles, input int ackAt,
                             input logic [0:31] rd);
        MemWrite_in = we;
        MemToReg_in = ld;
        addr_in     = addr;
        wdata_in    = wdata;
        DSize_in    = size;
        loadSign_in = sgn;
        #1;
        obsStall = stall_out ? 1 : 0;
        stepClk();
        obsAddr  = mem_addr;
        obsBe    = mem_be;
        obsWe    = mem_we;
        obsWdata = mem_wdata;
        obsReq   = mem_req;
        for (int c = 1; c <= busyCycles; c++) begin
            if (c == ackAt) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end
            #1;
            if (stall_out) obsStall++;
            stepClk();
            mem_ack = 1'b0;
        end
        clearInputs();
        #1;
        obsDoneStall = stall_out;
        obsDoneReq   = mem_req;
        obsRdata     = rdata_out;
        obsErr       = bus_err_out;
        stepClk();
    endtask

    task automatic test_reset();
        clearInputs();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        reset     = 1'b1;
        stepClk();
        stepClk();
        reset = 1'b0;
        #1;
        checks++;
        if ({stall_out, misalign_out, bus_err_out, mem_req, mem_we} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {stall_out, misalign_out, bus_err_out, mem_req, mem_we});
        end
        checks++;
        if ({rdata_out, mem_addr, mem_wdata, mem_be} !== 100'h0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h/%b exp=0", rdata_out, mem_addr, mem_wdata, mem_be);
        end
        stepClk();
    endtask

    task automatic test_word_load();
        runAccess(1'b0, 1'b1, 32'h0000_0100, 32'h0, 2'b10, 1'b0, 3, 3, 32'hDEAD_BEEF);
        checks++;
        if (obsAddr !== 32'h0000_0100) begin
            failures++; $display("FAIL wload_addr got=%h exp=00000100", obsAddr);
        end
        checks++;
        if ({obsBe, obsWe, obsReq} !== 6'b1111_0_1) begin
            failures++; $display("FAIL wload_bus got=%b exp=111101", {obsBe, obsWe, obsReq});
        end
        checks++;
        if (obsStall !== 4) begin
            failures++; $display("FAIL wload_stall_cycles got=%0d exp=4", obsStall);
        end
        checks++;
        if ({obsDoneStall, obsDoneReq} !== 2'b00) begin
            failures++; $display("FAIL wload_done_ctrl got=%b exp=00", {obsDoneStall, obsDoneReq});
        end
        checks++;
        if (obsRdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL wload_rdata got=%h exp=deadbeef", obsRdata);
        end
    endtask

    task automatic test_sub_word_load();
        runAccess(1'b0, 1'b1, 32'h0000_0203, 32'h0, 2'b00, 1'b1, 1, 1, 32'h1122_33F0);
        checks++;
        if (obsBe !== 4'b0001) begin
            failures++; $display("FAIL bload_be got=%b exp=0001", obsBe);
        end
        checks++;
        if (obsRdata !== 32'hFFFF_FFF0) begin
            failures++; $display("FAIL bload_signed got=%h exp=fffffff0", obsRdata);
        end
        checks++;
        if (obsStall !== 2) begin
            failures++; $display("FAIL bload_stall_cycles got=%0d exp=2", obsStall);
        end
        runAccess(1'b0, 1'b1, 32'h0000_0203, 32'h0, 2'b00, 1'b0, 2, 2, 32'h1122_33F0);
        checks++;
        if (obsRdata !== 32'h0000_00F0) begin
            failures++; $display("FAIL bload_unsigned got=%h exp=000000f0", obsRdata);
        end
        runAccess(1'b0, 1'b1, 32'h0000_0200, 32'h0, 2'b00, 1'b1, 1, 1, 32'h9122_33F0);
        checks++;
        if ({obsBe, obsRdata} !== {4'b1000, 32'hFFFF_FF91}) begin
            failures++; $display("FAIL bload_lane0 got=%b/%h exp=1000/ffffff91", obsBe, obsRdata);
        end
        runAccess(1'b0, 1'b1, 32'h0000_0202, 32'h0, 2'b01, 1'b1, 1, 1, 32'h1234_8001);
        checks++;
        if ({obsBe, obsRdata} !== {4'b0011, 32'hFFFF_8001}) begin
            failures++; $display("FAIL hload_signed got=%b/%h exp=0011/ffff8001", obsBe, obsRdata);
        end
        runAccess(1'b0, 1'b1, 32'h0000_0200, 32'h0, 2'b01, 1'b0, 1, 1, 32'h9234_8001);
        checks++;
        if ({obsBe, obsRdata} !== {4'b1100, 32'h0000_9234}) begin
            failures++; $display("FAIL hload_unsigned got=%b/%h exp=1100/00009234", obsBe, obsRdata);
        end
    endtask

    task automatic test_store();
        runAccess(1'b1, 1'b0, 32'h0000_0302, 32'h0000_ABCD, 2'b01, 1'b0, 2, 2, 32'h5555_5555);
        checks++;
        if ({obsWe, obsBe, obsAddr} !== {1'b1, 4'b0011, 32'h0000_0300}) begin
            failures++; $display("FAIL hstore_bus got=%b/%b/%h exp=1/0011/00000300", obsWe, obsBe, obsAddr);
        end
        checks++;
        if (obsWdata !== 32'hABCD_ABCD) begin
            failures++; $display("FAIL hstore_wdata got=%h exp=abcdabcd", obsWdata);
        end
        checks++;
        if (obsRdata !== 32'h0000_9234) begin
            failures++; $display("FAIL store_keeps_rdata got=%h exp=00009234", obsRdata);
        end
    endtask

    task automatic test_back_to_back();
        // Issued in the IDLE cycle immediately after the previous DONE.
        runAccess(1'b1, 1'b1, 32'h0000_0401, 32'h1234_5678, 2'b00, 1'b0, 1, 1, 32'h0);
        checks++;
        if ({obsStall, obsReq} !== {32'd2, 1'b1}) begin
            failures++; $display("FAIL b2b_accept got=%0d/%b exp=2/1", obsStall, obsReq);
        end
        checks++;
        if ({obsWe, obsBe, obsWdata} !== {1'b1, 4'b0100, 32'h7878_7878}) begin
            failures++; $display("FAIL bstore_bus got=%b/%b/%h exp=1/0100/78787878", obsWe, obsBe, obsWdata);
        end
        runAccess(1'b1, 1'b0, 32'h0000_0500, 32'hCAFE_F00D, 2'b11, 1'b0, 1, 1, 32'h0);
        checks++;
        if ({obsBe, obsWdata} !== {4'b1111, 32'hCAFE_F00D}) begin
            failures++; $display("FAIL wstore_bus got=%b/%h exp=1111/cafef00d", obsBe, obsWdata);
        end
    endtask

    task automatic test_misalign();
        logic [0:31] addrs [2];
        logic [0:1]  sizes [2];
        addrs[0] = 32'h0000_0101; sizes[0] = 2'b10;
        addrs[1] = 32'h0000_0103; sizes[1] = 2'b01;
        for (int i = 0; i < 2; i++) begin
            MemToReg_in = 1'b1;
            addr_in     = addrs[i];
            DSize_in    = sizes[i];
            #1;
            checks++;
            if ({misalign_out, stall_out, mem_req} !== 3'b100) begin
                failures++;
                $display("FAIL misalign_pulse[%0d] got=%b exp=100", i, {misalign_out, stall_out, mem_req});
            end
            stepClk();
            clearInputs();
            #1;
            checks++;
            if ({misalign_out, stall_out, mem_req} !== 3'b000) begin
                failures++;
                $display("FAIL misalign_no_bus[%0d] got=%b exp=000", i, {misalign_out, stall_out, mem_req});
            end
            stepClk();
        end
    endtask

    task automatic test_reset_in_busy();
        MemToReg_in = 1'b1;
        addr_in     = 32'h0000_0600;
        DSize_in    = 2'b10;
        stepClk();
        checks++;
        if (mem_req !== 1'b1) begin
            failures++; $display("FAIL rstbusy_req_before got=%b exp=1", mem_req);
        end
        reset = 1'b1;
        clearInputs();
        stepClk();
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_req, stall_out, rdata_out} !== {2'b00, 32'h0}) begin
            failures++; $display("FAIL rstbusy_idle got=%b%b/%h exp=00/00000000", mem_req, stall_out, rdata_out);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        stepClk();
        mem_ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if ({mem_req, stall_out, bus_err_out, rdata_out} !== {3'b000, 32'h0}) begin
                failures++;
                $display("FAIL late_ack_ignored[%0d] got=%b%b%b/%h exp=000/00000000",
                         c, mem_req, stall_out, bus_err_out, rdata_out);
            end
            stepClk();
        end
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        runAccess(1'b0, 1'b1, 32'h0000_0700, 32'h0, 2'b10, 1'b0, 4, 4, 32'h1357_9BDF);
        checks++;
        if ({obsErr, obsRdata} !== {1'b0, 32'h1357_9BDF}) begin
            failures++; $display("FAIL ack_last_cycle got=%b/%h exp=0/13579bdf", obsErr, obsRdata);
        end
        runAccess(1'b0, 1'b1, 32'h0000_0704, 32'h0, 2'b10, 1'b0, 4, 0, 32'h0);
        checks++;
        if ({obsErr, obsDoneReq, obsDoneStall, obsRdata} !== {3'b100, 32'h0}) begin
            failures++;
            $display("FAIL timeout_abort got=%b%b%b/%h exp=100/00000000",
                     obsErr, obsDoneReq, obsDoneStall, obsRdata);
        end
        checks++;
        if (obsStall !== 5) begin
            failures++; $display("FAIL timeout_stall_cycles got=%0d exp=5", obsStall);
        end
        #1;
        checks++;
        if ({bus_err_out, mem_req, stall_out} !== 3'b000) begin
            failures++; $display("FAIL timeout_single_pulse got=%b exp=000", {bus_err_out, mem_req, stall_out});
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        test_reset();
        test_word_load();
        test_sub_word_load();
        test_store();
        test_back_to_back();
        test_misalign();
        test_reset_in_busy();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
